// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device over an open-drain PS2_CLK/PS2_DAT pair.
// The host first pulls the clock low for INHIBIT_CYCLES (request-to-send), then
// pulls data low (start bit) and releases the clock. From then on the device
// supplies the clock. On each device falling edge the host presents the next
// frame bit: 8 data bits LSB first, odd parity, stop (released). On the 11th
// falling edge the host samples the device ACK. Timeouts guard both the wait
// for the first device edge and the whole frame.
//
// Ports:
//   clk, resetN            system clock, asynchronous active-low reset
//   tx_valid/tx_data       command byte offer (accepted when tx_ready=1)
//   tx_ready               1 when idle
//   busy                   1 in any state other than IDLE
//   tx_done/tx_status      one-cycle completion pulse; 00 ack, 01 nak, 10 timeout
//   ps2_clk_in/ps2_dat_in  raw asynchronous line levels
//   ps2_clk_oe/ps2_dat_oe  1 = pull the line low, 0 = release
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int START_TIMEOUT  = 375000,
  parameter int FRAME_TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic [1:0] tx_status,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // Counter must hold the largest of the three limits so that parameter
  // overrides never make a limit unreachable.
  localparam int CNT_TOP =
    (START_TIMEOUT > FRAME_TIMEOUT)
      ? ((START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES)
      : ((FRAME_TIMEOUT > INHIBIT_CYCLES) ? FRAME_TIMEOUT : INHIBIT_CYCLES);
  localparam int CW = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] INH_C = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] ST_C  = CW'(START_TIMEOUT);
  localparam logic [CW-1:0] FT_C  = CW'(FRAME_TIMEOUT);
  localparam logic [CW-1:0] SAT_C = '1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_INHIBIT  = 4'd1;
  localparam logic [3:0] S_RTS      = 4'd2;
  localparam logic [3:0] S_DATA     = 4'd3;
  localparam logic [3:0] S_STOP     = 4'd4;
  localparam logic [3:0] S_ACK      = 4'd5;
  localparam logic [3:0] S_WAIT_REL = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_FAIL     = 4'd8;

  // Line synchronizers; idle level of both lines is high.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  logic fall;
  assign fall = clk_prev_q & ~clk_sync_q;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    idx_q, idx_d;
  logic [8:0]    frame_q, frame_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          done_q, done_d;
  logic [1:0]    status_q, status_d;
  logic          go_fail;

  // Saturating so a stuck counter can never wrap back below a limit.
  assign cnt_inc = (cnt_q == SAT_C) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    idx_d    = idx_q;
    frame_d  = frame_q;
    clk_oe_d = 1'b0;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    status_d = status_q;
    go_fail  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d  = {~^tx_data, tx_data};
          status_d = 2'b00;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_C) begin
          // Start bit already on the line, clock released: hand over to device.
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = S_RTS;
        end else if (cnt_inc == INH_C) begin
          dat_oe_d = 1'b1;
        end else begin
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
        end
      end
      S_RTS: begin
        dat_oe_d = 1'b1;
        if (fall) begin
          dat_oe_d = ~frame_q[0];
          idx_d    = 4'd1;
          cnt_d    = '0;
          state_d  = S_DATA;
        end else if (cnt_inc == ST_C) begin
          go_fail = 1'b1;
        end
      end
      S_DATA: begin
        if (fall) begin
          dat_oe_d = ~frame_q[idx_q];
          if (idx_q == 4'd8) state_d = S_STOP;
          else               idx_d   = idx_q + 4'd1;
        end else if (cnt_inc == FT_C) begin
          go_fail = 1'b1;
        end
      end
      S_STOP: begin
        if (fall) begin
          dat_oe_d = 1'b0;
          state_d  = S_ACK;
        end else if (cnt_inc == FT_C) begin
          go_fail = 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          status_d = {1'b0, dat_sync_q};
          state_d  = S_WAIT_REL;
        end else if (cnt_inc == FT_C) begin
          go_fail = 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_inc == FT_C) begin
          go_fail = 1'b1;
        end
      end
      S_DONE: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_FAIL: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
    if (go_fail) begin
      dat_oe_d = 1'b0;
      clk_oe_d = 1'b0;
      done_d   = 1'b1;
      status_d = 2'b10;
      state_d  = S_FAIL;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      frame_q  <= 9'd0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign tx_ready   = ~busy;
  assign tx_done    = done_q;
  assign tx_status  = status_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with scaled-down timing limits and a behavioural
// PS/2 device that supplies the clock, samples bits on rising edges and
// optionally ACKs.
module tb_ps2_host_tx;
  localparam int IC   = 200;
  localparam int ST   = 2500;
  localparam int FT   = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done;
  logic [1:0] tx_status;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .START_TIMEOUT(ST), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .resetN(resetN), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_status(tx_status),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clk_oe_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [1:0] last_status = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2_clk_oe === 1'b1) clk_oe_cnt <= clk_oe_cnt + 1;
    if (tx_done === 1'b1) begin
      done_cnt    <= done_cnt + 1;
      last_status <= tx_status;
      done_cyc    <= cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame bit as the device should see it after edge i+1.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i < 8)  return d[i];
    if (i == 8) return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_status(input int n, input bit ack);
    if (n < 11) return 2'b10;
    return ack ? 2'b00 : 2'b01;
  endfunction

  int         dev_edges = 0;
  logic [9:0] dev_bits;
  logic       dev_start;
  int         fall_cyc = 0;

  // Device: waits for request-to-send, then produces n clock pulses.
  task automatic device(input int n, input bit ack);
    int w;
    dev_edges = 0;
    dev_bits  = '1;
    dev_start = 1'b1;
    if (n == 0) return;
    w = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && w < IC + 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= IC + 100) begin
      chk("rts_wait", 0, 1);
      return;
    end
    repeat (10) @(negedge clk);
    dev_start = ps2_dat_in;
    for (int e = 1; e <= n; e++) begin
      if (e == 11 && ack) dev_dat = 1'b0;
      dev_clk   = 1'b0;
      dev_edges = e;
      if (e == 1) fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      if (e <= 10) dev_bits[e-1] = ps2_dat_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (e == 11) dev_dat = 1'b1;
    end
  endtask

  task automatic txn(input logic [7:0] d, input int n, input bit ack,
                     input logic [1:0] exp_st, input string tag);
    int d0, c0, acc_cyc, w;
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_before"}, tx_ready, 1);
    d0 = done_cnt;
    c0 = clk_oe_cnt;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    chk({tag, "_busy_after_accept"}, busy, 1);
    // Offer a different byte while busy; it must be ignored.
    tx_data = ~d;
    fork
      device(n, ack);
      begin
        w = 0;
        while (done_cnt == d0 && w < 40000) begin
          @(negedge clk);
          #1;
          w++;
          if (w == 100) tx_valid = 1'b0;
          if (tx_done !== 1'b1 && done_cnt == d0 && busy !== 1'b1) busy_ok = 1'b0;
        end
        tx_valid = 1'b0;
        chk({tag, "_done_seen"}, (w < 40000), 1);
      end
    join
    repeat (5) @(negedge clk);
    #1;
    chk({tag, "_status"}, last_status, exp_st);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_busy_throughout"}, busy_ok, 1);
    chk({tag, "_clk_oe_len"}, clk_oe_cnt - c0, IC);
    chk({tag, "_released"}, {ps2_clk_oe, ps2_dat_oe, tx_ready}, 3'b001);
    if (n > 0) chk({tag, "_start_bit"}, dev_start, 0);
    for (int e = 1; e <= n && e <= 10; e++)
      chk($sformatf("%s_bit%0d", tag, e - 1), dev_bits[e-1], exp_bit(d, e - 1));
    if (n == 0)
      chk({tag, "_start_timeout_len"}, done_cyc - acc_cyc, IC + 1 + ST);
    else if (n < 11)
      chk({tag, "_frame_timeout_len"}, done_cyc - fall_cyc, 3 + FT);
  endtask

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         ack;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int d0, w, n;
    bit ack;
    logic [7:0] d;

    tbl[0] = '{8'hED, 11, 1'b1, 2'b00};
    tbl[1] = '{8'hF4, 11, 1'b0, 2'b01};
    tbl[2] = '{8'h00,  0, 1'b1, 2'b10};
    tbl[3] = '{8'h5A,  4, 1'b1, 2'b10};
    tbl[4] = '{8'hFF, 11, 1'b1, 2'b00};
    tbl[5] = '{8'h01, 10, 1'b1, 2'b10};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {ps2_clk_oe, ps2_dat_oe, busy, tx_ready, tx_done, tx_status},
        7'b0001000);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_after_rst", {ps2_clk_oe, ps2_dat_oe, busy, tx_ready, tx_done}, 5'b00010);

    for (int i = 0; i < 6; i++)
      txn(tbl[i].data, tbl[i].n, tbl[i].ack, tbl[i].st, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of the data bits.
    @(negedge clk);
    d0 = done_cnt;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    fork
      device(11, 1'b1);
      begin
        w = 0;
        while (dev_edges < 3 && w < 5000) begin
          @(negedge clk);
          w++;
        end
        chk("rst_mid_reach_bit3", (w < 5000), 1);
        repeat (8) @(negedge clk);
        chk("rst_mid_busy_before", busy, 1);
        #3;
        resetN = 1'b0;
        #1;
        chk("rst_mid_released", {ps2_clk_oe, ps2_dat_oe, busy, tx_ready}, 4'b0001);
        #4;
        resetN = 1'b1;
      end
    join
    repeat (50) @(negedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt, d0);

    txn(8'hF4, 11, 1'b1, 2'b00, "after_rst");

    // Randomized transfers against the reference model.
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      n   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 11;
      txn(d, n, ack, exp_status(n, ack), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
